sdr_rd: RTL
===========

// Module: sdr_rd
// PURPOSE
//  SDRAM read engine; sdr_top drives it while its FSM is in S_READ (peer of the write engine).
//  One request = ACTIVE, tRCD wait, READ with auto-precharge, capture one BL-word burst, wait tRP.
//  Streams the burst upstream as rdata/vld, then pulses done so sdr_top returns to S_IDLE.
//  Pins are muxed onto the SDRAM bus by sdr_top; this block only samples DQ and never drives it.
// PARAMETERS
//  BL     8  burst length in words; must match the mode register written by sdr_init (1,2,4,8)
//  CL     3  CAS latency in clk cycles (2 or 3)
//  TRCD   3  ACTIVE-to-READ delay in clk cycles (18 ns at 167 MHz)
//  TRP    3  NOP cycles after the last data word before done
//  CNT_W  4  width of the shared wait/burst counter; 2^CNT_W > max(BL,CL,TRCD,TRP)
// PORTS
//  clk            in   1   167 MHz clock
//  rst_n          in   1   asynchronous reset, active-low
//  sdr_rd_req     in   1   read request; sampled only in IDLE
//  sdr_raddr      in   32  byte-free word address: BA=[24:23], row=[22:10], col=[8:0]; [31:25],[9] ignored
//  sdr_rd_busy    out  1   high from the cycle after req acceptance until done
//  sdr_rd_done    out  1   one-cycle pulse at end of access
//  sdr_rdata_out  out  16  read data word
//  sdr_rd_vld     out  1   rdata_out valid this cycle; no backpressure
//  sdr_rd_CKE     out  1   clock enable
//  sdr_rd_nCS     out  1   chip select, active-low
//  sdr_rd_nRAS    out  1   row address strobe, active-low
//  sdr_rd_nCAS    out  1   column address strobe, active-low
//  sdr_rd_nWE     out  1   write enable, active-low
//  sdr_rd_BA      out  2   bank address
//  sdr_rd_A       out  13  address bus
//  sdr_rd_DQM     out  2   data mask
//  sdr_DQ_in      in   16  DQ pins as sampled input
// BEHAVIOUR
//  Reset (async, rst_n low): state IDLE, counter 0, busy/done/vld 0, rdata 0, CKE 1, DQM 2'b00.
//  Command pins in reset: NOP {nCS,nRAS,nCAS,nWE}=4'b0111, BA 0, A 0.
//  Outputs: all registered. Commands are 4-bit {nCS,nRAS,nCAS,nWE}: NOP 0111, ACTIVE 0011, READ 0101.
//  FSM: IDLE -> ACT -> TRCD -> RD -> CASW -> BURST -> PRE -> DONE -> IDLE.
//  IDLE: on sdr_rd_req latch BA/row/col; ACT next.
//  ACT: drive ACTIVE with BA, A=row; 1 cycle.
//  TRCD: NOP for TRCD-1 cycles.
//  RD: drive READ with BA, A={2'b00,1'b1(A10 auto-precharge),1'b0,col[8:0]}; 1 cycle.
//  CASW: NOP for CL cycles.
//  BURST: each cycle register DQ into rdata_out, vld=1; BL cycles.
//  PRE: NOP, vld=0, for TRP cycles.
//  DONE: done=1 for 1 cycle, busy=0 after.
//  Timing: req sampled in cycle 0 -> ACTIVE in cycle 1 -> READ in cycle 1+TRCD.
//  vld in cycles 1+TRCD+CL+1 .. 1+TRCD+CL+BL; done in cycle 1+TRCD+CL+BL+TRP+1.
//  Defaults: READ 4, vld 8..15, done 19.
//  req while busy: ignored, never queued; must be re-issued after done.
//  req held high through DONE: new access starts only from IDLE, so earliest ACTIVE is 2 cycles after done.
//  Counter: loaded with (phase length-1), decrements to 0, then state advances; no wrap.
//  Reset mid-operation: abort immediately to reset values; a partial burst is discarded with no done.
//  Open-row recovery relies on sdr_init's re-init sequence.
//  Counts of 0 are illegal: TRCD>=1, CL>=2, BL>=1, TRP>=1. Check with elaboration-time asserts.
// STRUCTURE
//  sdr_pkg: command encodings (CMD_NOP, CMD_ACT, CMD_RD), address slice positions (BA/ROW/COL msb/lsb),
//           default CL/BL/TRCD/TRP. sdr_init and sdr_wr share the same package.
//  No sub-module: one FSM, one CNT_W counter and an address latch, all in this file.
// TESTING
//  1 Reset: hold rst_n low -> cmd 0111, CKE 1, DQM 00, vld/done/busy 0, rdata 0.
//  2 Defaults: req=1 in cycle 0, raddr=0x0180_0C05 (BA 3, row 3, col 5)
//    -> ACT cycle 1, BA 3, A 0x0003; READ cycle 4, A 0x0405.
//    -> model DQ 0xA000+i -> vld cycles 8..15, rdata 0xA000..0xA007; done cycle 19.
//  3 Address boundary: raddr=0x01FF_FDFF -> BA 3, ACT A 0x1FFF, READ A 0x05FF (bit 9 ignored).
//  4 req held high continuously -> exactly one access per IDLE visit, next ACTIVE 2 cycles after done.
//    Extra req pulses during BURST produce no extra vld.
//  5 Reset mid-burst: rst_n low in cycle 11 -> all outputs at reset values that cycle, no done.
//    Fresh req after release completes normally.
//  6 Param sweep: CL=2, BL=1, TRCD=2 -> READ cycle 3, single vld cycle 6, done cycle 10 (TRP=3).

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared SDRAM controller definitions: command encodings, address slicing,
// default timing parameters and the read-engine state type.
package sdr_pkg;

    // Commands as {nCS, nRAS, nCAS, nWE}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;

    // Word-address slice positions
    localparam int BA_MSB  = 24;
    localparam int BA_LSB  = 23;
    localparam int ROW_MSB = 22;
    localparam int ROW_LSB = 10;
    localparam int COL_MSB = 8;
    localparam int COL_LSB = 0;

    // Default timing, matching the mode register written at init
    localparam int DEF_CL   = 3;
    localparam int DEF_BL   = 8;
    localparam int DEF_TRCD = 3;
    localparam int DEF_TRP  = 3;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ACT,
        RD_TRCD,
        RD_RD,
        RD_CASW,
        RD_BURST,
        RD_PRE,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/sdr_rd.sv
// SDRAM read engine: ACTIVE, tRCD wait, READ with auto-precharge, capture a
// BL-word burst from DQ, wait tRP, then pulse done. All outputs registered;
// the pin values for a cycle are computed from the state being entered.
module sdr_rd
    import sdr_pkg::*;
#(
    parameter int BL    = DEF_BL,
    parameter int CL    = DEF_CL,
    parameter int TRCD  = DEF_TRCD,
    parameter int TRP   = DEF_TRP,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdr_rd_req,
    input  logic [31:0] sdr_raddr,
    output logic        sdr_rd_busy,
    output logic        sdr_rd_done,
    output logic [15:0] sdr_rdata_out,
    output logic        sdr_rd_vld,
    output logic        sdr_rd_CKE,
    output logic        sdr_rd_nCS,
    output logic        sdr_rd_nRAS,
    output logic        sdr_rd_nCAS,
    output logic        sdr_rd_nWE,
    output logic [1:0]  sdr_rd_BA,
    output logic [12:0] sdr_rd_A,
    output logic [1:0]  sdr_rd_DQM,
    input  logic [15:0] sdr_DQ_in
);

    localparam int MAX_LEN = (BL > CL) ? ((BL > TRCD) ? ((BL > TRP) ? BL : TRP) : ((TRCD > TRP) ? TRCD : TRP))
                                       : ((CL > TRCD) ? ((CL > TRP) ? CL : TRP) : ((TRCD > TRP) ? TRCD : TRP));

    if (TRCD < 1 || CL < 2 || BL < 1 || TRP < 1) begin : g_bad_timing
        $error("sdr_rd: illegal zero-length phase (need TRCD>=1, CL>=2, BL>=1, TRP>=1)");
    end
    if ((2 ** CNT_W) <= MAX_LEN) begin : g_bad_cnt_w
        $error("sdr_rd: CNT_W too narrow for the longest phase");
    end

    // Counter load values (phase length - 1); the tRCD phase lasts TRCD-1 cycles
    // and is skipped entirely when TRCD is 1.
    localparam logic [CNT_W-1:0] LD_TRCD  = CNT_W'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [CNT_W-1:0] LD_CASW  = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] LD_BURST = CNT_W'(BL - 1);
    localparam logic [CNT_W-1:0] LD_PRE   = CNT_W'(TRP - 1);

    rd_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         lat_ba_q, lat_ba_d;
    logic [12:0]        lat_row_q, lat_row_d;
    logic [8:0]         lat_col_q, lat_col_d;

    logic [3:0]         pin_cmd_q, pin_cmd_d;
    logic [1:0]         pin_ba_q, pin_ba_d;
    logic [12:0]        pin_a_q, pin_a_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               cke_q;
    logic [1:0]         dqm_q;

    // Address bits outside BA/row/col are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{sdr_raddr[31:25], sdr_raddr[9]};

    // State register, phase counter and request address latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            cnt_q     <= '0;
            lat_ba_q  <= '0;
            lat_row_q <= '0;
            lat_col_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the same pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_ba_q  <= lat_ba_d;
            lat_row_q <= lat_row_d;
            lat_col_q <= lat_col_d;
        end
    end

    // Next-state: advance on counter expiry, load the next phase length on entry
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_ba_d  = lat_ba_q;
        lat_row_d = lat_row_q;
        lat_col_d = lat_col_q;
        case (state_q)
            RD_IDLE: begin
                if (sdr_rd_req) begin
                    lat_ba_d  = sdr_raddr[BA_MSB:BA_LSB];
                    lat_row_d = sdr_raddr[ROW_MSB:ROW_LSB];
                    lat_col_d = sdr_raddr[COL_MSB:COL_LSB];
                    state_d   = RD_ACT;
                end
            end
            RD_ACT: begin
                if (TRCD > 1) begin
                    state_d = RD_TRCD;
                    cnt_d   = LD_TRCD;
                end else begin
                    state_d = RD_RD;
                end
            end
            RD_TRCD: begin
                if (cnt_q == '0) state_d = RD_RD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RD_RD: begin
                state_d = RD_CASW;
                cnt_d   = LD_CASW;
            end
            RD_CASW: begin
                if (cnt_q == '0) begin
                    state_d = RD_BURST;
                    cnt_d   = LD_BURST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_BURST: begin
                if (cnt_q == '0) begin
                    state_d = RD_PRE;
                    cnt_d   = LD_PRE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_PRE: begin
                if (cnt_q == '0) state_d = RD_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // Output decode from the state being entered, so pins line up with that state
    always_comb begin
        pin_cmd_d = CMD_NOP;
        pin_ba_d  = '0;
        pin_a_d   = '0;
        rdata_d   = rdata_q;
        vld_d     = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != RD_IDLE);
        case (state_d)
            RD_ACT: begin
                pin_cmd_d = CMD_ACT;
                pin_ba_d  = lat_ba_d;
                pin_a_d   = lat_row_d;
            end
            RD_RD: begin
                pin_cmd_d = CMD_RD;
                pin_ba_d  = lat_ba_d;
                pin_a_d   = {2'b00, 1'b1, 1'b0, lat_col_d};
            end
            RD_BURST: begin
                rdata_d = sdr_DQ_in;
                vld_d   = 1'b1;
            end
            RD_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers; reset presents NOP with CKE high and no masking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_cmd_q <= CMD_NOP;
            pin_ba_q  <= '0;
            pin_a_q   <= '0;
            rdata_q   <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cke_q     <= 1'b1;
            dqm_q     <= 2'b00;
        end else begin
            pin_cmd_q <= pin_cmd_d;
            pin_ba_q  <= pin_ba_d;
            pin_a_q   <= pin_a_d;
            rdata_q   <= rdata_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cke_q     <= 1'b1;
            dqm_q     <= 2'b00;
        end
    end

    assign {sdr_rd_nCS, sdr_rd_nRAS, sdr_rd_nCAS, sdr_rd_nWE} = pin_cmd_q;
    assign sdr_rd_BA     = pin_ba_q;
    assign sdr_rd_A      = pin_a_q;
    assign sdr_rdata_out = rdata_q;
    assign sdr_rd_vld    = vld_q;
    assign sdr_rd_done   = done_q;
    assign sdr_rd_busy   = busy_q;
    assign sdr_rd_CKE    = cke_q;
    assign sdr_rd_DQM    = dqm_q;

endmodule
